channel_fir_model: RTL and testbench
====================================

// Module: channel_fir_model
// PURPOSE
// - Synthesizable discrete-time model of a lossy serial-link channel: applies a programmable
//   FIR pulse response to a stream of signed baud-rate samples.
// - Sits between the TX driver sample stream and the RX front end in emulation builds.
// - Stands in for the analog PWL channel model.
// PARAMETERS
// - NIN   default 8   signed input sample width
// - NTAP  default 8   number of FIR taps (tap 0 = newest sample)
// - NCOEF default 12  signed coefficient width, Q1.(NCOEF-1); FRAC = NCOEF-1
// - NOUT  default 10  signed output sample width
// PORTS
// - clk         in   1      sample clock; all logic on posedge
// - rst         in   1      synchronous, active-high reset
// - in_vld      in   1      din valid this cycle
// - din         in   NIN    signed channel input sample
// - coef_we     in   1      coefficient write strobe
// - coef_addr   in   3      tap index to write, width clog2(NTAP)
// - coef_wdata  in   NCOEF  signed coefficient value
// - out_vld     out  1      dout valid
// - dout        out  NOUT   signed channel output sample
// - out_sat     out  1      dout was clipped this sample
// BEHAVIOUR
// - Reset values:
//   - delay line x[0..NTAP-1] = 0; dout = 0; out_vld = 0; out_sat = 0.
//   - Coefficients reload defaults h = {102, 1229, 410, 164, 61, 0, 0, 0}
//     (= 0.05, 0.60, 0.20, 0.08, 0.03).
//   - Reset asserted mid-stream discards all in-flight samples.
// - Delay line:
//   - Updates only on a clk edge where in_vld = 1: x[0] <= din, x[i] <= x[i-1].
//   - When in_vld = 0 the line holds.
// - MAC (combinational):
//   - acc = sum over i of x[i]*h[i], full precision, width NIN+NCOEF+clog2(NTAP).
// - Scaling: r = (acc + 2**(FRAC-1)) >>> FRAC, i.e. round half toward +inf.
// - Saturation and output register:
//   - r clipped to [-2**(NOUT-1), 2**(NOUT-1)-1] and registered into dout.
//   - out_sat = 1 on the same cycle dout is clipped.
// - Handshake and latency:
//   - out_vld <= registered in_vld, so out_vld is in_vld delayed 2 cycles.
//   - A sample captured at edge k drives dout after edge k+1.
//   - When out_vld = 0, dout and out_sat hold their last values.
// - Coefficient writes:
//   - A write at edge k updates h[coef_addr]; it is used from the MAC evaluated after edge k.
//   - Writes with coef_addr >= NTAP are ignored.
//   - A write simultaneous with in_vld is legal: the captured sample is convolved with the new
//     coefficient.
//   - rst has priority over coef_we.
// - No internal state machine. The only state is the delay line, the coefficients, the output
//   registers and the valid pipe.
// CONFIGURATION
// - CHANNEL_NOISE_EN defined:
//   - Adds a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst.
//   - The LFSR advances on every in_vld = 1 edge.
//   - noise = signed lfsr[2:0] (range -4..+3) is added to r before saturation.
// - CHANNEL_NOISE_EN undefined: noise is zero and no LFSR logic exists; output bit-exact to the
//   equation above.
// TESTING
// - Impulse: default coefs, din = 64 for one valid sample, then 0s
//   -> dout = 3, 38, 13, 5, 2, then 0; out_sat = 0.
// - Saturation: write all 8 taps = 2047.
//   - din = 127 constant -> dout = 511 with out_sat = 1.
//   - din = -128 constant -> dout = -512 with out_sat = 1.
// - DC gain: default coefs, din = 127 constant for at least 8 samples -> dout = 122.
// - Valid gaps:
//   - Impulse sent with in_vld toggling 1,0,1,0 -> identical dout sequence on out_vld cycles.
//   - dout holds during out_vld = 0.
// - Coef write:
//   - Write h[1] = -1024 then impulse 64 -> second output -32.
//   - Write to addr >= NTAP has no effect.
// - Reset mid-stream: rst for 1 cycle during the impulse response
//   -> next cycle dout = 0, out_vld = 0, coefs back to defaults.

Source files
------------

// File: rtl/channel_fir_if.sv
// Sample-stream and coefficient-write bundle for channel_fir_model.
// The driver side (TX sample source / coefficient loader) uses master, the channel model uses slave.
interface channel_fir_if #(
  parameter int NIN   = 8,
  parameter int NTAP  = 8,
  parameter int NCOEF = 12,
  parameter int NOUT  = 10
);
  localparam int AD_W = (NTAP > 1) ? $clog2(NTAP) : 1;

  logic                    in_vld;
  logic signed [NIN-1:0]   din;
  logic                    coef_we;
  logic [AD_W-1:0]         coef_addr;
  logic signed [NCOEF-1:0] coef_wdata;
  logic                    out_vld;
  logic signed [NOUT-1:0]  dout;
  logic                    out_sat;

  modport master (
    output in_vld, din, coef_we, coef_addr, coef_wdata,
    input  out_vld, dout, out_sat
  );

  modport slave (
    input  in_vld, din, coef_we, coef_addr, coef_wdata,
    output out_vld, dout, out_sat
  );
endinterface

// File: rtl/channel_fir_model.sv
// Lossy serial-link channel: programmable FIR pulse response over signed baud-rate samples,
// rounded, saturated and registered. Define CHANNEL_NOISE_EN to add LFSR noise before saturation.
module channel_fir_model #(
  parameter int NIN   = 8,
  parameter int NTAP  = 8,
  parameter int NCOEF = 12,
  parameter int NOUT  = 10
) (
  input logic           clk,
  input logic           rst,
  channel_fir_if.slave  bus
);
  localparam int FRAC  = NCOEF - 1;
  localparam int ACC_W = NIN + NCOEF + $clog2(NTAP);
  localparam int RW    = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [RW-1:0]    SAT_MAX = RW'(2 ** (NOUT - 1) - 1);
  localparam logic signed [RW-1:0]    SAT_MIN = RW'(-(2 ** (NOUT - 1)));

  // Default pulse response: 0.05, 0.60, 0.20, 0.08, 0.03 in Q1.11.
  function automatic int def_coef(input int idx);
    case (idx)
      0:       return 102;
      1:       return 1229;
      2:       return 410;
      3:       return 164;
      4:       return 61;
      default: return 0;
    endcase
  endfunction

  logic signed [NIN-1:0]   x_q [NTAP];
  logic signed [NCOEF-1:0] h_q [NTAP];
  logic                    vld_q;
  logic                    out_vld_q;
  logic signed [NOUT-1:0]  dout_q, dout_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] acc, rnd, r;
  logic signed [RW-1:0]    rn;
  logic signed [RW-1:0]    noise;

`ifdef CHANNEL_NOISE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (bus.in_vld) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign noise = RW'($signed(lfsr_q[2:0]));
`else
  assign noise = '0;
`endif

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAP; i++) begin
      acc = acc + ACC_W'(x_q[i]) * ACC_W'(h_q[i]);
    end
    rnd    = acc + HALF;
    r      = rnd >>> FRAC;
    rn     = RW'(r) + noise;
    dout_d = rn[NOUT-1:0];
    sat_d  = 1'b0;
    if (rn > SAT_MAX) begin
      dout_d = SAT_MAX[NOUT-1:0];
      sat_d  = 1'b1;
    end else if (rn < SAT_MIN) begin
      dout_d = SAT_MIN[NOUT-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the coefficient bank is a handful of flops with meaningful defaults, so it is
      // reset like any other register rather than treated as an uninitialised memory.
      for (int i = 0; i < NTAP; i++) begin
        x_q[i] <= '0;
        h_q[i] <= NCOEF'(def_coef(i));
      end
      vld_q     <= 1'b0;
      out_vld_q <= 1'b0;
      dout_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      if (bus.in_vld) begin
        x_q[0] <= bus.din;
        for (int i = 1; i < NTAP; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      if (bus.coef_we && (int'(bus.coef_addr) < NTAP)) begin
        h_q[bus.coef_addr] <= bus.coef_wdata;
      end
      vld_q     <= bus.in_vld;
      out_vld_q <= vld_q;
      if (vld_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign bus.out_vld = out_vld_q;
  assign bus.dout    = dout_q;
  assign bus.out_sat = sat_q;
endmodule

// File: tb/tb_channel_fir_model.sv
// Directed bench for channel_fir_model: a default 8-tap instance plus a 6-tap instance
// that exposes out-of-range coefficient addresses.
module tb_channel_fir_model;
  localparam int NIN = 8, NCOEF = 12, NOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  channel_fir_if #(.NIN(NIN), .NTAP(8), .NCOEF(NCOEF), .NOUT(NOUT)) bus  ();
  channel_fir_if #(.NIN(NIN), .NTAP(6), .NCOEF(NCOEF), .NOUT(NOUT)) bus6 ();

  channel_fir_model #(.NIN(NIN), .NTAP(8), .NCOEF(NCOEF), .NOUT(NOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  channel_fir_model #(.NIN(NIN), .NTAP(6), .NCOEF(NCOEF), .NOUT(NOUT)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  int imp_exp [6] = '{3, 38, 13, 5, 2, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d);
    bus.in_vld = v;
    bus.din    = NIN'(d);
  endtask

  task automatic write_coef(input int addr, input int val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'(addr);
    bus.coef_wdata = NCOEF'(val);
    tick();
    bus.coef_we    = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 0);
      tick();
    end
    drive(1'b0, 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.dout !== NOUT'(0) || bus.out_vld !== 1'b0 || bus.out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: dout=%0d out_vld=%b out_sat=%b expected 0/0/0",
               bus.dout, bus.out_vld, bus.out_sat);
    end
    n_tests++;
    if (bus6.dout !== NOUT'(0) || bus6.out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset6: dout=%0d out_vld=%b expected 0/0", bus6.dout, bus6.out_vld);
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    drive(1'b1, 64);
    tick();
    n_tests++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL impulse_latency: out_vld=%b expected 0", bus.out_vld);
    end
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 0);
      tick();
      n_tests++;
      if (bus.out_vld !== 1'b1 || bus.dout !== NOUT'(imp_exp[j]) || bus.out_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL impulse[%0d]: dout=%0d vld=%b sat=%b expected %0d/1/0",
                 j, bus.dout, bus.out_vld, bus.out_sat, imp_exp[j]);
      end
    end
    flush();
  endtask

  task automatic test_dc_gain();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 127);
      tick();
    end
    n_tests++;
    if (bus.dout !== NOUT'(122) || bus.out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL dc_gain: dout=%0d sat=%b expected 122/0", bus.dout, bus.out_sat);
    end
    flush();
  endtask

  task automatic test_saturation();
    drive(1'b0, 0);
    for (int a = 0; a < 8; a++) write_coef(a, 2047);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 127);
      tick();
    end
    n_tests++;
    if (bus.dout !== NOUT'(511) || bus.out_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos: dout=%0d sat=%b expected 511/1", bus.dout, bus.out_sat);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, -128);
      tick();
    end
    n_tests++;
    if (bus.dout !== NOUT'(-512) || bus.out_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg: dout=%0d sat=%b expected -512/1", bus.dout, bus.out_sat);
    end
    drive(1'b0, 0);
    do_reset();
  endtask

  task automatic test_valid_gaps();
    int idx  = 0;
    int last = 0;
    for (int c = 0; c < 12; c++) begin
      drive((c % 2) == 0, (c == 0) ? 64 : 0);
      tick();
      n_tests++;
      if (bus.out_vld !== ((c >= 1) && (((c - 1) % 2) == 0))) begin
        n_fail++;
        $display("FAIL gaps_vld[%0d]: out_vld=%b", c, bus.out_vld);
      end
      if (bus.out_vld === 1'b1 && idx < 6) begin
        last = imp_exp[idx];
        idx++;
      end
      n_tests++;
      if (bus.dout !== NOUT'(last)) begin
        n_fail++;
        $display("FAIL gaps_dout[%0d]: dout=%0d expected %0d", c, bus.dout, last);
      end
    end
    flush();
  endtask

  task automatic test_coef_write();
    write_coef(1, -1024);
    drive(1'b1, 64);
    tick();
    drive(1'b1, 0);
    tick();
    n_tests++;
    if (bus.dout !== NOUT'(3)) begin
      n_fail++;
      $display("FAIL coef_first: dout=%0d expected 3", bus.dout);
    end
    tick();
    n_tests++;
    if (bus.dout !== NOUT'(-32)) begin
      n_fail++;
      $display("FAIL coef_second: dout=%0d expected -32", bus.dout);
    end
    flush();
    // Coefficient write on the same edge as the sample capture.
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'd0;
    bus.coef_wdata = NCOEF'(2047);
    drive(1'b1, 64);
    tick();
    bus.coef_we = 1'b0;
    drive(1'b1, 0);
    tick();
    n_tests++;
    if (bus.dout !== NOUT'(64)) begin
      n_fail++;
      $display("FAIL coef_simul: dout=%0d expected 64", bus.dout);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64);
    tick();
    drive(1'b1, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.dout !== NOUT'(0) || bus.out_vld !== 1'b0 || bus.out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: dout=%0d vld=%b sat=%b expected 0/0/0",
               bus.dout, bus.out_vld, bus.out_sat);
    end
    drive(1'b1, 64);
    tick();
    drive(1'b1, 0);
    tick();
    n_tests++;
    if (bus.dout !== NOUT'(3)) begin
      n_fail++;
      $display("FAIL reset_mid_h0: dout=%0d expected 3", bus.dout);
    end
    tick();
    n_tests++;
    if (bus.dout !== NOUT'(38)) begin
      n_fail++;
      $display("FAIL reset_mid_h1: dout=%0d expected 38", bus.dout);
    end
    flush();
  endtask

  task automatic test_bad_addr();
    bus6.coef_we    = 1'b1;
    bus6.coef_addr  = 3'd6;
    bus6.coef_wdata = NCOEF'(2047);
    tick();
    bus6.coef_addr  = 3'd7;
    bus6.coef_wdata = NCOEF'(-2048);
    tick();
    bus6.coef_we = 1'b0;
    bus6.in_vld  = 1'b1;
    bus6.din     = NIN'(64);
    tick();
    for (int j = 0; j < 6; j++) begin
      bus6.din = '0;
      tick();
      n_tests++;
      if (bus6.dout !== NOUT'(imp_exp[j]) || bus6.out_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_addr[%0d]: dout=%0d sat=%b expected %0d/0",
                 j, bus6.dout, bus6.out_sat, imp_exp[j]);
      end
    end
    bus6.in_vld = 1'b0;
  endtask

  initial begin
    bus.in_vld = 1'b0;  bus.din = '0;  bus.coef_we = 1'b0;  bus.coef_addr = '0;  bus.coef_wdata = '0;
    bus6.in_vld = 1'b0; bus6.din = '0; bus6.coef_we = 1'b0; bus6.coef_addr = '0; bus6.coef_wdata = '0;
    test_reset();
    test_impulse();
    test_dc_gain();
    test_saturation();
    test_valid_gaps();
    test_coef_write();
    test_reset_mid();
    test_bad_addr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
